// File: rtl/arm_banked_regfile_if.sv
// Register file access bundle between decode/writeback and the banked
// register file.
//   master : decode/writeback side (drives mode, read addresses, write ports)
//   slave  : register file side (returns read data, PC write request, SPSR)
interface arm_banked_regfile_if #(
    parameter int DATA_W = 32
);
    logic [4:0]        mode;
    logic              user_bank;
    logic [3:0]        rn;
    logic [3:0]        rm;
    logic [3:0]        rs;
    logic [DATA_W-1:0] rn_data;
    logic [DATA_W-1:0] rm_data;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] pc_in;
    logic              wr0_en;
    logic [3:0]        wr0_addr;
    logic [DATA_W-1:0] wr0_data;
    logic              wr1_en;
    logic [3:0]        wr1_addr;
    logic [DATA_W-1:0] wr1_data;
    logic              pc_we;
    logic [DATA_W-1:0] pc_wdata;
    logic              spsr_we;
    logic [DATA_W-1:0] spsr_wdata;
    logic [DATA_W-1:0] spsr_rdata;

    modport master (
        output mode, user_bank, rn, rm, rs, pc_in,
        output wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
        output spsr_we, spsr_wdata,
        input  rn_data, rm_data, rs_data, pc_we, pc_wdata, spsr_rdata
    );

    modport slave (
        input  mode, user_bank, rn, rm, rs, pc_in,
        input  wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
        input  spsr_we, spsr_wdata,
        output rn_data, rm_data, rs_data, pc_we, pc_wdata, spsr_rdata
    );
endinterface

// File: rtl/arm_banked_regfile.sv
// ARM7TDMI-class banked general register file.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of arm_banked_regfile_if
//                - three combinational read ports (rn/rm/rs), r15 reads pc_in
//                - two write ports, port 1 wins on a physical-register clash
//                - r15 writes are reported on pc_we/pc_wdata, never stored
//                - one SPSR per exception mode, read/written per current mode
//
// Physical register index map (5-bit):
//   0-7   r0-r7 common
//   8-12  r8-r12 USR/shared
//   13-17 r8-r12 FIQ (only built when FIQ_BANK=1)
//   18+2*bank+{0,1}  r13/r14 for bank USR,FIQ,IRQ,SVC,ABT,UND
//   30-31 unused padding so any 5-bit index is in range
module arm_banked_regfile #(
    parameter int                DATA_W    = 32,
    parameter bit                FIQ_BANK  = 1'b1,
    parameter bit                BYPASS    = 1'b1,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input logic                  clk,
    input logic                  rst_n,
    arm_banked_regfile_if.slave  bus
);
    localparam logic [2:0] B_USR = 3'd0;
    localparam logic [2:0] B_FIQ = 3'd1;
    localparam logic [2:0] B_IRQ = 3'd2;
    localparam logic [2:0] B_SVC = 3'd3;
    localparam logic [2:0] B_ABT = 3'd4;
    localparam logic [2:0] B_UND = 3'd5;
    localparam int         NPHYS = 32;

    logic [2:0] mode_bank;   // selects SPSR
    logic [2:0] reg_bank;    // selects register mapping (user_bank forces USR)

    // SYS and every unknown encoding share the USR bank.
    always_comb begin
        mode_bank = B_USR;
        case (bus.mode)
            5'b10001: mode_bank = B_FIQ;
            5'b10010: mode_bank = B_IRQ;
            5'b10011: mode_bank = B_SVC;
            5'b10111: mode_bank = B_ABT;
            5'b11011: mode_bank = B_UND;
            default:  mode_bank = B_USR;
        endcase
    end

    assign reg_bank = bus.user_bank ? B_USR : mode_bank;

    // Logical address + bank -> physical index. Address 15 yields a harmless
    // index; callers gate writes and override reads for r15.
    function automatic logic [4:0] phys_idx(input logic [3:0] a, input logic [2:0] b);
        logic [4:0] idx;
        if (a < 4'd8)
            idx = {1'b0, a};
        else if (a < 4'd13)
            idx = (FIQ_BANK && b == B_FIQ) ? {1'b0, a} + 5'd5 : {1'b0, a};
        else
            idx = 5'd18 + {1'b0, b, 1'b0} + {4'b0, ~a[0]};
        return idx;
    endfunction

    logic       w0_hit, w1_hit, w0_pc, w1_pc;
    logic [4:0] w0_idx, w1_idx;

    assign w0_hit = bus.wr0_en && (bus.wr0_addr != 4'hF);
    assign w1_hit = bus.wr1_en && (bus.wr1_addr != 4'hF);
    assign w0_pc  = bus.wr0_en && (bus.wr0_addr == 4'hF);
    assign w1_pc  = bus.wr1_en && (bus.wr1_addr == 4'hF);
    assign w0_idx = phys_idx(bus.wr0_addr, reg_bank);
    assign w1_idx = phys_idx(bus.wr1_addr, reg_bank);

    assign bus.pc_we    = w0_pc | w1_pc;
    assign bus.pc_wdata = w1_pc ? bus.wr1_data : bus.wr0_data;

    logic [DATA_W-1:0] phys [NPHYS];

    for (genvar i = 0; i < NPHYS; i++) begin : g_reg
        if (i >= 30 || (!FIQ_BANK && i >= 13 && i <= 17)) begin : g_none
            assign phys[i] = RESET_VAL;
        end else begin : g_ff
            logic [DATA_W-1:0] q;
            // Port 1 takes priority so a clash commits wr1_data.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    q <= RESET_VAL;
                else if (w1_hit && w1_idx == 5'(i))
                    q <= bus.wr1_data;
                else if (w0_hit && w0_idx == 5'(i))
                    q <= bus.wr0_data;
            end
            assign phys[i] = q;
        end
    end

    logic [2:0][3:0]        raddr;
    logic [2:0][DATA_W-1:0] rdata;

    assign raddr = {bus.rs, bus.rm, bus.rn};

    for (genvar p = 0; p < 3; p++) begin : g_rd
        logic [4:0]        idx;
        logic [DATA_W-1:0] d;
        assign idx = phys_idx(raddr[p], reg_bank);
        // Later assignments take precedence: port 1 over port 0, r15 over all.
        always_comb begin
            d = phys[idx];
            if (BYPASS && w0_hit && w0_idx == idx) d = bus.wr0_data;
            if (BYPASS && w1_hit && w1_idx == idx) d = bus.wr1_data;
            if (raddr[p] == 4'hF)                  d = bus.pc_in;
        end
        assign rdata[p] = d;
    end

    assign bus.rn_data = rdata[0];
    assign bus.rm_data = rdata[1];
    assign bus.rs_data = rdata[2];

    // Entry 0 (USR/SYS) and the padding entries read as zero.
    logic [7:0][DATA_W-1:0] spsr_vec;

    assign spsr_vec[0] = '0;
    assign spsr_vec[6] = '0;
    assign spsr_vec[7] = '0;

    for (genvar b = 1; b < 6; b++) begin : g_spsr
        logic [DATA_W-1:0] q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                q <= RESET_VAL;
            else if (bus.spsr_we && mode_bank == 3'(b))
                q <= bus.spsr_wdata;
        end
        assign spsr_vec[b] = q;
    end

    assign bus.spsr_rdata = spsr_vec[mode_bank];

endmodule

// File: tb/tb_arm_banked_regfile.sv
// Directed bench for arm_banked_regfile. Two instances see identical stimulus:
//   u0: FIQ_BANK=1, BYPASS=1, RESET_VAL=0 (fully checked per vector)
//   u1: FIQ_BANK=0, BYPASS=0, RESET_VAL=0x5A5A0000 (rn_data and SPSR checked)
module tb_arm_banked_regfile;
    localparam logic [4:0]  USR = 5'b10000, FIQ = 5'b10001, IRQ = 5'b10010,
                            SVC = 5'b10011, ABT = 5'b10111, UND = 5'b11011,
                            SYS = 5'b11111;
    localparam logic [31:0] PC  = 32'h0000_8008;
    localparam logic [31:0] R1  = 32'h5A5A_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [4:0]  mode;
    logic        user_bank;
    logic [3:0]  rn, rm, rs;
    logic [31:0] pc_in;
    logic        wr0_en, wr1_en, spsr_we;
    logic [3:0]  wr0_addr, wr1_addr;
    logic [31:0] wr0_data, wr1_data, spsr_wdata;

    arm_banked_regfile_if #(.DATA_W(32)) if0 ();
    arm_banked_regfile_if #(.DATA_W(32)) if1 ();

    assign if0.mode = mode;       assign if1.mode = mode;
    assign if0.user_bank = user_bank; assign if1.user_bank = user_bank;
    assign if0.rn = rn;           assign if1.rn = rn;
    assign if0.rm = rm;           assign if1.rm = rm;
    assign if0.rs = rs;           assign if1.rs = rs;
    assign if0.pc_in = pc_in;     assign if1.pc_in = pc_in;
    assign if0.wr0_en = wr0_en;   assign if1.wr0_en = wr0_en;
    assign if0.wr0_addr = wr0_addr; assign if1.wr0_addr = wr0_addr;
    assign if0.wr0_data = wr0_data; assign if1.wr0_data = wr0_data;
    assign if0.wr1_en = wr1_en;   assign if1.wr1_en = wr1_en;
    assign if0.wr1_addr = wr1_addr; assign if1.wr1_addr = wr1_addr;
    assign if0.wr1_data = wr1_data; assign if1.wr1_data = wr1_data;
    assign if0.spsr_we = spsr_we; assign if1.spsr_we = spsr_we;
    assign if0.spsr_wdata = spsr_wdata; assign if1.spsr_wdata = spsr_wdata;

    arm_banked_regfile #(.DATA_W(32), .FIQ_BANK(1'b1), .BYPASS(1'b1), .RESET_VAL(32'h0))
        u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    arm_banked_regfile #(.DATA_W(32), .FIQ_BANK(1'b0), .BYPASS(1'b0), .RESET_VAL(R1))
        u1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    typedef struct {
        logic [4:0]  m;
        logic        ub;
        logic [3:0]  a_n, a_m, a_s;
        logic        w0e;
        logic [3:0]  w0a;
        logic [31:0] w0d;
        logic        w1e;
        logic [3:0]  w1a;
        logic [31:0] w1d;
        logic        se;
        logic [31:0] sd;
        logic [31:0] e_n, e_m, e_s;
        logic        e_pwe;
        logic [31:0] e_pwd, e_sp, e_n1, e_sp1;
    } vec_t;

    vec_t vq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic add(input logic [4:0] m, input logic ub,
                       input logic [3:0] a_n, input logic [3:0] a_m, input logic [3:0] a_s,
                       input logic w0e, input logic [3:0] w0a, input logic [31:0] w0d,
                       input logic w1e, input logic [3:0] w1a, input logic [31:0] w1d,
                       input logic se, input logic [31:0] sd,
                       input logic [31:0] e_n, input logic [31:0] e_m, input logic [31:0] e_s,
                       input logic e_pwe, input logic [31:0] e_pwd, input logic [31:0] e_sp,
                       input logic [31:0] e_n1, input logic [31:0] e_sp1);
        vec_t v;
        v.m = m; v.ub = ub; v.a_n = a_n; v.a_m = a_m; v.a_s = a_s;
        v.w0e = w0e; v.w0a = w0a; v.w0d = w0d;
        v.w1e = w1e; v.w1a = w1a; v.w1d = w1d;
        v.se = se; v.sd = sd;
        v.e_n = e_n; v.e_m = e_m; v.e_s = e_s;
        v.e_pwe = e_pwe; v.e_pwd = e_pwd; v.e_sp = e_sp;
        v.e_n1 = e_n1; v.e_sp1 = e_sp1;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %h want %h", nm, idx, act, exp);
        end
    endtask

    task automatic idle();
        user_bank = 1'b0;
        wr0_en = 1'b0; wr0_addr = 4'd0; wr0_data = 32'd0;
        wr1_en = 1'b0; wr1_addr = 4'd0; wr1_data = 32'd0;
        spsr_we = 1'b0; spsr_wdata = 32'd0;
    endtask

    logic [4:0] ml [7];

    initial begin
        mode = USR; rn = 4'd0; rm = 4'd0; rs = 4'd0; pc_in = PC;
        idle();

        //  mode ub rn rm rs | w0 e/a/d        | w1 e/a/d         | spsr we/d      | exp rn rm rs pcwe pcwd spsr | u1 rn spsr
        add(USR, 0,  3,13,15, 0, 0,32'h0,      0, 0,32'h0,       0,32'h0,        32'h0,32'h0,PC,      0,32'h0,   32'h0,       R1,     32'h0);
        add(USR, 0,  3,13, 0, 1, 3,32'h11,     1,13,32'h22,      0,32'h0,        32'h11,32'h22,32'h0, 0,32'h11,  32'h0,       R1,     32'h0);
        add(SVC, 0, 13, 3,14, 1,13,32'h33,     0, 0,32'h0,       0,32'h0,        32'h33,32'h11,32'h0, 0,32'h33,  32'h0,       R1,     R1);
        add(USR, 0, 13, 3,14, 0, 0,32'h0,      0, 0,32'h0,       0,32'h0,        32'h22,32'h11,32'h0, 0,32'h0,   32'h0,       32'h22, 32'h0);
        add(SVC, 0, 13, 3,13, 0, 0,32'h0,      0, 0,32'h0,       0,32'h0,        32'h33,32'h11,32'h33,0,32'h0,   32'h0,       32'h33, R1);
        add(USR, 0,  9, 3, 0, 1, 9,32'hA,      0, 0,32'h0,       0,32'h0,        32'hA,32'h11,32'h0,  0,32'hA,   32'h0,       R1,     32'h0);
        add(FIQ, 0,  9, 3,13, 0, 0,32'h0,      1, 9,32'hB,       0,32'h0,        32'hB,32'h11,32'h0,  0,32'h0,   32'h0,       32'hA,  R1);
        add(USR, 0,  9, 3, 0, 0, 0,32'h0,      0, 0,32'h0,       0,32'h0,        32'hA,32'h11,32'h0,  0,32'h0,   32'h0,       32'hB,  32'h0);
        add(FIQ, 0,  9,13, 8, 0, 0,32'h0,      0, 0,32'h0,       0,32'h0,        32'hB,32'h0,32'h0,   0,32'h0,   32'h0,       32'hB,  R1);
        add(USR, 0,  5, 9, 0, 1, 5,32'h100,    1, 5,32'h200,     0,32'h0,        32'h200,32'hA,32'h0, 0,32'h100, 32'h0,       R1,     32'h0);
        add(USR, 0,  5, 9, 3, 0, 0,32'h0,      0, 0,32'h0,       0,32'h0,        32'h200,32'hA,32'h11,0,32'h0,   32'h0,       32'h200,32'h0);
        add(IRQ, 1, 14,13, 3, 1,14,32'h44,     0, 0,32'h0,       0,32'h0,        32'h44,32'h22,32'h11,0,32'h44,  32'h0,       R1,     R1);
        add(USR, 0, 14,13, 0, 0, 0,32'h0,      0, 0,32'h0,       0,32'h0,        32'h44,32'h22,32'h0, 0,32'h0,   32'h0,       32'h44, 32'h0);
        add(IRQ, 0, 14,13, 0, 0, 0,32'h0,      0, 0,32'h0,       0,32'h0,        32'h0,32'h0,32'h0,   0,32'h0,   32'h0,       R1,     R1);
        add(USR, 0, 15,15, 5, 1,15,32'h1000,   0, 0,32'h0,       0,32'h0,        PC,PC,32'h200,       1,32'h1000,32'h0,       PC,     32'h0);
        add(USR, 0,  5, 3,14, 0, 0,32'h0,      0, 0,32'h0,       0,32'h0,        32'h200,32'h11,32'h44,0,32'h0,  32'h0,       32'h200,32'h0);
        add(USR, 0, 15, 2, 0, 1,15,32'h1000,   1,15,32'h2000,    0,32'h0,        PC,32'h0,32'h0,      1,32'h2000,32'h0,       PC,     32'h0);
        add(USR, 0,  2, 0, 0, 1, 2,32'h55,     1,15,32'h3000,    0,32'h0,        32'h55,32'h0,32'h0,  1,32'h3000,32'h0,       R1,     32'h0);
        add(ABT, 0,  0, 2, 0, 0, 0,32'h0,      0, 0,32'h0,       1,32'h600000D7, 32'h0,32'h55,32'h0,  0,32'h0,   32'h0,       R1,     R1);
        add(ABT, 0,  0, 0, 0, 0, 0,32'h0,      0, 0,32'h0,       0,32'h0,        32'h0,32'h0,32'h0,   0,32'h0,   32'h600000D7,R1,     32'h600000D7);
        add(UND, 0,  0, 0, 0, 0, 0,32'h0,      0, 0,32'h0,       0,32'h0,        32'h0,32'h0,32'h0,   0,32'h0,   32'h0,       R1,     R1);
        add(USR, 0,  0, 0, 0, 0, 0,32'h0,      0, 0,32'h0,       0,32'h0,        32'h0,32'h0,32'h0,   0,32'h0,   32'h0,       R1,     32'h0);
        add(SYS, 0,  0, 0, 0, 0, 0,32'h0,      0, 0,32'h0,       1,32'hFFFFFFFF, 32'h0,32'h0,32'h0,   0,32'h0,   32'h0,       R1,     32'h0);
        add(ABT, 0,  0, 0, 0, 0, 0,32'h0,      0, 0,32'h0,       0,32'h0,        32'h0,32'h0,32'h0,   0,32'h0,   32'h600000D7,R1,     32'h600000D7);
        add(FIQ, 0,  0, 0, 0, 0, 0,32'h0,      0, 0,32'h0,       0,32'h0,        32'h0,32'h0,32'h0,   0,32'h0,   32'h0,       R1,     R1);
        add(IRQ, 0,  0, 0, 0, 0, 0,32'h0,      0, 0,32'h0,       0,32'h0,        32'h0,32'h0,32'h0,   0,32'h0,   32'h0,       R1,     R1);
        add(SVC, 0,  0, 0, 0, 0, 0,32'h0,      0, 0,32'h0,       0,32'h0,        32'h0,32'h0,32'h0,   0,32'h0,   32'h0,       R1,     R1);
        add(UND, 0,  0, 0, 0, 0, 0,32'h0,      0, 0,32'h0,       0,32'h0,        32'h0,32'h0,32'h0,   0,32'h0,   32'h0,       R1,     R1);
        add(SYS, 0, 13, 9, 5, 0, 0,32'h0,      0, 0,32'h0,       0,32'h0,        32'h22,32'hA,32'h200,0,32'h0,   32'h0,       32'h22, 32'h0);
        add(5'b00000,0,13,14,0,0,0,32'h0,      0, 0,32'h0,       0,32'h0,        32'h22,32'h44,32'h0, 0,32'h0,   32'h0,       32'h22, 32'h0);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Outputs are checked mid-cycle, before the edge that commits the writes.
        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            mode = vq[i].m; user_bank = vq[i].ub;
            rn = vq[i].a_n; rm = vq[i].a_m; rs = vq[i].a_s;
            wr0_en = vq[i].w0e; wr0_addr = vq[i].w0a; wr0_data = vq[i].w0d;
            wr1_en = vq[i].w1e; wr1_addr = vq[i].w1a; wr1_data = vq[i].w1d;
            spsr_we = vq[i].se; spsr_wdata = vq[i].sd;
            #2;
            chk("rn_data",    i, if0.rn_data,          vq[i].e_n);
            chk("rm_data",    i, if0.rm_data,          vq[i].e_m);
            chk("rs_data",    i, if0.rs_data,          vq[i].e_s);
            chk("pc_we",      i, {31'd0, if0.pc_we},   {31'd0, vq[i].e_pwe});
            chk("pc_wdata",   i, if0.pc_wdata,         vq[i].e_pwd);
            chk("spsr_rdata", i, if0.spsr_rdata,       vq[i].e_sp);
            chk("u1_rn_data", i, if1.rn_data,          vq[i].e_n1);
            chk("u1_spsr",    i, if1.spsr_rdata,       vq[i].e_sp1);
        end
        @(negedge clk);
        idle();

        // Asynchronous reset while a write is pending: clears immediately and
        // the write is never committed.
        @(negedge clk);
        mode = USR; rn = 4'd13; rm = 4'd3; rs = 4'd0;
        wr0_en = 1'b1; wr0_addr = 4'd3; wr0_data = 32'hFFFF;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_now_rn",    0, if0.rn_data, 32'h0);
        chk("rst_now_u1_rn", 0, if1.rn_data, R1);
        chk("rst_now_u1_rm", 0, if1.rm_data, R1);
        @(posedge clk);
        @(negedge clk);
        wr0_en = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("rst_pc_we", 0, {31'd0, if0.pc_we}, 32'h0);

        ml = '{USR, FIQ, IRQ, SVC, ABT, UND, SYS};
        for (int m = 0; m < 7; m++) begin
            mode = ml[m];
            for (int r = 0; r < 15; r++) begin
                rn = 4'(r); rm = 4'(r); rs = 4'(r);
                #1;
                chk("rst_rn", m * 16 + r, if0.rn_data, 32'h0);
                chk("rst_rs", m * 16 + r, if0.rs_data, 32'h0);
                chk("rst_u1", m * 16 + r, if1.rn_data, R1);
            end
            rn = 4'd15;
            #1;
            chk("rst_r15", m, if0.rn_data, PC);
            chk("rst_spsr",    m, if0.spsr_rdata, 32'h0);
            chk("rst_u1_spsr", m, if1.spsr_rdata, (m >= 1 && m <= 5) ? R1 : 32'h0);
        end

        // A write presented as reset releases commits on the next edge.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        mode = USR; rn = 4'd4;
        wr0_en = 1'b1; wr0_addr = 4'd4; wr0_data = 32'h77;
        rst_n = 1'b1;
        @(posedge clk);
        #1 wr0_en = 1'b0;
        #1;
        chk("rel_wr",    0, if0.rn_data, 32'h77);
        chk("rel_u1_wr", 0, if1.rn_data, 32'h77);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
